// File: rtl/op_sequencer.sv
// op_sequencer: steps a core through the enabled operations (LOAD, ACCUMULATE,
// READ, ROLLBACK) for a latched number of passes. Each operation gets a start
// pulse, a bounded wait for core_done, and a fixed idle gap before the next one.
module op_sequencer #(
  parameter int ITER_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] iterations,
  input  logic [3:0]            op_enable,
  input  logic                  core_done,
  output logic [1:0]            core_operation,
  output logic                  core_start,
  output logic                  core_rollback,
  output logic                  busy,
  output logic                  run_done,
  output logic                  timeout_err,
  output logic [15:0]           ops_issued,
  output logic [7:0]            timeout_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [7:0]  TMO = 8'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP = 16'(GAP_CYCLES);

  logic [2:0]            state;
  logic [ITER_WIDTH-1:0] iter_q;
  logic [ITER_WIDTH-1:0] pass;
  logic [3:0]            en_q;
  logic [2:0]            idx;      // 0..3 = op slot, 4 = past the end of this pass
  logic [7:0]            wait_cnt;
  logic [15:0]           gap_cnt;

  logic                  found;
  logic [1:0]            sel;
  logic [ITER_WIDTH:0]   pass_nx;

  // Lowest enabled op slot at or after the current index.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (en_q[i] && (3'(i) >= idx)) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  assign pass_nx = {1'b0, pass} + 1'b1;

  // Sequencer state, registered outputs and per-run counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      iter_q         <= '0;
      pass           <= '0;
      en_q           <= 4'b0000;
      idx            <= 3'd0;
      wait_cnt       <= 8'd0;
      gap_cnt        <= 16'd0;
      core_operation <= 2'b00;
      core_start     <= 1'b0;
      core_rollback  <= 1'b0;
      busy           <= 1'b0;
      run_done       <= 1'b0;
      timeout_err    <= 1'b0;
      ops_issued     <= 16'd0;
      timeout_count  <= 8'd0;
    end else begin
      core_start    <= 1'b0;
      core_rollback <= 1'b0;
      run_done      <= 1'b0;
      if (state != S_IDLE && abort) begin
        // Counters and the sticky error are left as they stand.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              iter_q        <= iterations;
              en_q          <= op_enable;
              ops_issued    <= 16'd0;
              timeout_count <= 8'd0;
              timeout_err   <= 1'b0;
              idx           <= 3'd0;
              pass          <= '0;
              busy          <= 1'b1;
              state         <= S_SELECT;
            end
          end
          S_SELECT: begin
            if (iter_q == '0 || en_q == 4'b0000) begin
              state <= S_FINISH;
            end else if (found) begin
              // Op code is slot+1 modulo 4, so ROLLBACK (slot 3) maps to 2'b00.
              idx            <= {1'b0, sel};
              core_start     <= 1'b1;
              core_operation <= sel + 2'd1;
              core_rollback  <= (sel == 2'd3);
              if (ops_issued != 16'hFFFF) ops_issued <= ops_issued + 16'd1;
              state          <= S_ISSUE;
            end else begin
              idx <= 3'd0;
              if (pass_nx == {1'b0, iter_q}) state <= S_FINISH;
              else                           pass  <= pass + 1'b1;
            end
          end
          S_ISSUE: begin
            wait_cnt <= 8'd1;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            // A completion on the expiry cycle still wins over the timeout.
            if (core_done) begin
              gap_cnt <= 16'd1;
              state   <= S_GAP;
            end else if (wait_cnt == TMO) begin
              timeout_err <= 1'b1;
              if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
              gap_cnt     <= 16'd1;
              state       <= S_GAP;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP) begin
              idx   <= idx + 3'd1;
              state <= S_SELECT;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          S_FINISH: begin
            run_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: table of runs plus random runs checked against a
// pass/op-list model, and directed abort, reset and timeout-timing sequences.
module tb_op_sequencer;

  localparam int TMO = 8;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, core_done;
  logic [7:0]  iterations;
  logic [3:0]  op_enable;
  logic [1:0]  core_operation;
  logic        core_start, core_rollback, busy, run_done, timeout_err;
  logic [15:0] ops_issued;
  logic [7:0]  timeout_count;

  int checks = 0;
  int fails  = 0;

  op_sequencer #(.ITER_WIDTH(8), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .iterations(iterations), .op_enable(op_enable), .core_done(core_done),
    .core_operation(core_operation), .core_start(core_start),
    .core_rollback(core_rollback), .busy(busy), .run_done(run_done),
    .timeout_err(timeout_err), .ops_issued(ops_issued),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] it;
    logic [3:0] en;
    int         dly;    // core_done this many cycles after core_start; <0 never
    bit         noise;  // stray start/core_done while busy
    bit         sa;     // abort together with start
    int         x_ops;
    int         x_tc;
    int         x_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] it, input logic [3:0] en);
    @(negedge clk);
    iterations = it; op_enable = en; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cs(input string nm);
    int n = 0;
    while (!core_start && n < 400) begin @(negedge clk); n++; end
    if (!core_start) begin
      checks++; fails++;
      $display("FAIL %s actual=no_core_start required=core_start", nm);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int codes[4] = '{1, 2, 3, 0};
    int exp_q[$];
    int got_q[$];
    int cyc, since, first, last, mingap;
    bit fin;
    for (int p = 0; p < int'(v.it); p++)
      for (int b = 0; b < 4; b++)
        if (v.en[b]) exp_q.push_back(codes[b]);
    @(negedge clk);
    iterations = v.it; op_enable = v.en; start = 1'b1; abort = v.sa;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk({nm, " cleared_at_start"},
        {busy, timeout_err, 7'd0} | ops_issued | timeout_count, 32'h100);
    cyc = 1; since = -1; first = -1; last = -1; mingap = 1000; fin = 0;
    while (!fin && cyc < 20000) begin
      core_done = 1'b0; start = 1'b0;
      if (core_start) begin
        got_q.push_back(int'(core_operation));
        chk({nm, " rollback_with_op"}, core_rollback, core_operation == 2'b00);
        if (first < 0) first = cyc;
        else if (cyc - last - 1 < mingap) mingap = cyc - last - 1;
        last = cyc; since = 0;
      end else begin
        if (core_rollback) chk({nm, " rollback_without_start"}, core_rollback, 0);
        if (since >= 0) since++;
      end
      if (since >= 0 && since == v.dly) begin core_done = 1'b1; since = -1; end
      if (v.noise) begin
        if (since == 0) core_done = 1'b1;
        if (since == 1) begin
          start = 1'b1; iterations = 8'($urandom); op_enable = 4'($urandom);
        end
      end
      if (run_done) fin = 1;
      else begin @(negedge clk); cyc++; end
    end
    core_done = 1'b0; start = 1'b0;
    if (!fin) begin
      checks++; fails++;
      $display("FAIL %s actual=no_run_done required=run_done", nm);
      return;
    end
    if (v.x_ops == 0) chk({nm, " run_done_latency"}, cyc, 3);
    else              chk({nm, " first_start_latency"}, first, 2);
    chk({nm, " ops_issued"}, ops_issued, v.x_ops);
    chk({nm, " timeout_count"}, timeout_count, v.x_tc);
    chk({nm, " timeout_err"}, timeout_err, v.x_err);
    chk({nm, " op_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s op[%0d]", nm, i), got_q[i], exp_q[i]);
    if (got_q.size() > 1) chk({nm, " min_gap_ok"}, mingap >= GAPC + 1, 1);
    @(negedge clk);
    chk({nm, " done_idle"}, {run_done, busy}, 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; core_done = 1'b0;
    iterations = 8'd0; op_enable = 4'd0;

    //          it    en       dly noise sa  ops  tc  err
    tbl[0]  = '{8'd1,   4'b1111,  3, 0, 0,   4,  0, 0};
    tbl[1]  = '{8'd3,   4'b0101,  2, 0, 0,   6,  0, 0};
    tbl[2]  = '{8'd1,   4'b1111, -1, 0, 0,   4,  4, 1};
    tbl[3]  = '{8'd2,   4'b0110, -1, 0, 0,   4,  4, 1};
    tbl[4]  = '{8'd0,   4'b1111,  3, 0, 0,   0,  0, 0};
    tbl[5]  = '{8'd5,   4'b0000,  3, 0, 0,   0,  0, 0};
    tbl[6]  = '{8'd2,   4'b1000,  8, 0, 0,   2,  0, 0};
    tbl[7]  = '{8'd2,   4'b0011,  9, 0, 0,   4,  4, 1};
    tbl[8]  = '{8'd2,   4'b1111,  1, 1, 0,   8,  0, 0};
    tbl[9]  = '{8'd1,   4'b0100,  4, 0, 1,   1,  0, 0};
    tbl[10] = '{8'd1,   4'b0010,  0, 0, 0,   1,  1, 1};
    tbl[11] = '{8'd200, 4'b0001,  1, 0, 0, 200,  0, 0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outputs", {core_operation, core_start, core_rollback, busy,
        run_done, timeout_err} | ops_issued | timeout_count, 0);

    // Abort in WAIT of the 2nd op after the 1st timed out: counters hold.
    start_run(8'd2, 4'b1111);
    wait_cs("abort_wait op1");
    @(negedge clk);
    wait_cs("abort_wait op2");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wait busy", busy, 0);
    chk("abort_wait ops_issued", ops_issued, 2);
    chk("abort_wait timeout_count", timeout_count, 1);
    chk("abort_wait timeout_err", timeout_err, 1);
    cnt = 0;
    repeat (8) begin @(negedge clk); cnt += core_start + run_done; end
    chk("abort_wait quiet", cnt, 0);
    chk("abort_wait ops_hold", ops_issued, 2);

    // Abort in the ISSUE cycle: that pulse stands, nothing follows.
    start_run(8'd1, 4'b1111);
    wait_cs("abort_issue");
    chk("abort_issue pulse", core_start, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_issue busy", busy, 0);
    chk("abort_issue ops_issued", ops_issued, 1);
    cnt = 0;
    repeat (12) begin @(negedge clk); cnt += core_start + run_done; end
    chk("abort_issue quiet", cnt, 0);

    // Reset mid-WAIT with start and abort also asserted.
    start_run(8'd1, 4'b1111);
    wait_cs("reset_wait");
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    chk("reset_wait outputs", {core_operation, core_start, core_rollback, busy,
        run_done, timeout_err} | ops_issued | timeout_count, 0);
    cnt = 0;
    repeat (12) begin @(negedge clk); cnt += core_start + run_done + busy; end
    chk("reset_wait quiet", cnt, 0);

    // Timeout lands exactly after TMO wait cycles.
    start_run(8'd1, 4'b0001);
    wait_cs("tmo_timing");
    repeat (TMO) @(negedge clk);
    chk("tmo_timing err_before", timeout_err, 0);
    @(negedge clk);
    chk("tmo_timing err_after", timeout_err, 1);
    chk("tmo_timing count", timeout_count, 1);
    cnt = 0;
    while (!run_done && cnt < 100) begin @(negedge clk); cnt++; end
    chk("tmo_timing run_done", run_done, 1);
    @(negedge clk);

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("tbl%0d", i));

    for (int r = 0; r < 20; r++) begin
      vec_t v;
      v.it    = 8'($urandom_range(0, 4));
      v.en    = 4'($urandom_range(0, 15));
      v.dly   = int'($urandom_range(0, 12)) - 1;
      v.noise = 1'($urandom_range(0, 1));
      v.sa    = 1'($urandom_range(0, 1));
      v.x_ops = int'(v.it) * $countones(v.en);
      v.x_tc  = (v.dly <= 0 || v.dly > TMO) ? v.x_ops : 0;
      v.x_err = (v.x_tc > 0) ? 1 : 0;
      run(v, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter ITER_WIDTH, default 8, width of iteration count.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT cycles per operation (1..255).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles between operations (>=1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin run; sampled only in IDLE.
REQ-007 abort  input  1  terminate run; sampled in any non-IDLE state.
REQ-008 iterations  input  ITER_WIDTH  passes over enabled op list; latched at start.
REQ-009 op_enable  input  4  bit0 LOAD, bit1 ACCUMULATE, bit2 READ, bit3 ROLLBACK; latched at start.
REQ-010 core_done  input  1  operation-complete pulse from core.
REQ-011 core_operation  output  2  op code: LOAD 2'b01, ACCUMULATE 2'b10, READ 2'b11, ROLLBACK 2'b00.
REQ-012 core_start  output  1  one-cycle operation start pulse; also drives latency timer op_start.
REQ-013 core_rollback  output  1  high with core_start when issued op is ROLLBACK.
REQ-014 busy  output  1  high in every non-IDLE state.
REQ-015 run_done  output  1  one-cycle pulse on normal run completion.
REQ-016 timeout_err  output  1  sticky; set on any timeout, cleared on accepted start.
REQ-017 ops_issued  output  16  core_start pulses this run; saturates 16'hFFFF.
REQ-018 timeout_count  output  8  timeouts this run; saturates 8'hFF.

Function
REQ-019 States SHALL be IDLE, SELECT, ISSUE, WAIT, GAP, FINISH; all outputs registered.
REQ-020 IDLE: start=1 -> latch iterations/op_enable, clear ops_issued/timeout_count/timeout_err, op index=0, pass=0, go SELECT.
REQ-021 SELECT: next enabled op at index >= current, order LOAD, ACCUMULATE, READ, ROLLBACK; found -> ISSUE; none -> pass+1, index=0; pass+1 == latched iterations -> FINISH, else stay SELECT.
REQ-022 SELECT SHALL go directly to FINISH when latched iterations==0 or op_enable==4'b0000.
REQ-023 ISSUE: core_start=1 exactly one cycle, core_operation set, ops_issued+1 (saturating), go WAIT.
REQ-024 core_operation SHALL hold its value from ISSUE through end of WAIT.
REQ-025 First core_start SHALL be asserted 2 cycles after the edge sampling start (IDLE->SELECT->ISSUE).
REQ-026 core_done SHALL be ignored outside WAIT, including the ISSUE cycle.
REQ-027 WAIT: cycle counter from 1; core_done=1 -> GAP; counter==TIMEOUT_CYCLES without core_done -> timeout_err=1, timeout_count+1 (saturating), GAP.
REQ-028 core_done in the same cycle timeout expires SHALL count as completion, no timeout.
REQ-029 GAP: exactly GAP_CYCLES cycles, then index+1 and SELECT.
REQ-030 FINISH: run_done=1 one cycle, -> IDLE; busy=0 from next cycle.
REQ-031 abort in non-IDLE state -> IDLE next edge, no run_done, no further core_start; counters and timeout_err hold.
REQ-032 abort in the ISSUE cycle SHALL not suppress that cycle's core_start; no further pulses.
REQ-033 start while busy SHALL be ignored; start and abort same IDLE cycle -> start wins.
REQ-034 ops_issued at run_done SHALL equal iterations x popcount(op_enable), saturated.

Reset
REQ-035 rst_n=0 at an edge -> IDLE; core_operation=2'b00, core_start=0, core_rollback=0, busy=0, run_done=0, timeout_err=0, ops_issued=0, timeout_count=0.
REQ-036 Reset mid-run SHALL abort without run_done; reset overrides start and abort.

Verification
REQ-037 iterations=1, op_enable=4'b1111, core_done 3 cycles after each core_start -> ops 01,10,11,00 in order, core_rollback only on 4th, ops_issued=4, run_done once, timeout_err=0.
REQ-038 iterations=3, op_enable=4'b0101 -> 6 pulses alternating 01/11, >=GAP_CYCLES+1 low cycles between pulses, ops_issued=6.
REQ-039 TIMEOUT_CYCLES=8, core_done never -> each op leaves WAIT after 8 cycles, timeout_err=1, timeout_count=popcount(op_enable), run_done still pulses.
REQ-040 iterations=0 or op_enable=0 -> no core_start, run_done 3 cycles after start edge, ops_issued=0.
REQ-041 abort during WAIT of 2nd op -> busy=0 next cycle, no run_done, ops_issued=2; later start runs and clears counters.
REQ-042 start pulses while busy, core_done outside WAIT, and rst_n=0 mid-WAIT -> ignored, ignored, all outputs at reset values after the edge.
